// File: rtl/free_addr_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : free_addr_arb_if
// Description : Bus bundle between the free-address arbiter, the free-list
//               FIFO read side and the four address-consuming ports.
//               The master modport is the arbiter's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface free_addr_arb_if #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
);
  // Free-list FIFO read side
  logic [DATA_WIDTH-1:0] iFifoData;
  logic                  iFifoEmpty;
  logic                  oFifoRd;

  // Per-port allocation enable and address handshakes
  logic [3:0]            iPortEn;
  logic                  iEptyAddrRdy0;
  logic                  iEptyAddrRdy1;
  logic                  iEptyAddrRdy2;
  logic                  iEptyAddrRdy3;
  logic [DATA_WIDTH-1:0] oEptyAddr0;
  logic [DATA_WIDTH-1:0] oEptyAddr1;
  logic [DATA_WIDTH-1:0] oEptyAddr2;
  logic [DATA_WIDTH-1:0] oEptyAddr3;
  logic                  oEptyAddrVld0;
  logic                  oEptyAddrVld1;
  logic                  oEptyAddrVld2;
  logic                  oEptyAddrVld3;

  // Allocation statistics
  logic [CNT_WIDTH-1:0]  oAllocCnt;

  modport master (
    input  iFifoData, iFifoEmpty, iPortEn,
    input  iEptyAddrRdy0, iEptyAddrRdy1, iEptyAddrRdy2, iEptyAddrRdy3,
    output oFifoRd,
    output oEptyAddr0, oEptyAddr1, oEptyAddr2, oEptyAddr3,
    output oEptyAddrVld0, oEptyAddrVld1, oEptyAddrVld2, oEptyAddrVld3,
    output oAllocCnt
  );

  modport slave (
    output iFifoData, iFifoEmpty, iPortEn,
    output iEptyAddrRdy0, iEptyAddrRdy1, iEptyAddrRdy2, iEptyAddrRdy3,
    input  oFifoRd,
    input  oEptyAddr0, oEptyAddr1, oEptyAddr2, oEptyAddr3,
    input  oEptyAddrVld0, oEptyAddrVld1, oEptyAddrVld2, oEptyAddrVld3,
    input  oAllocCnt
  );
endinterface
`default_nettype wire

// File: rtl/free_addr_arb.sv
`default_nettype none
// ============================================================================
// Module      : free_addr_arb
// Description : Distributes free buffer addresses from a single free-list
//               FIFO to four ports. Round-robin grant, one FIFO read per
//               cycle, one-entry holding register per port with a
//               valid/ready handshake, and a handshake counter.
// Revision    : 1.0 - initial release
// ============================================================================
module free_addr_arb #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic       iClk,
  input  wire logic       iRst_n,
  free_addr_arb_if.master bus
);

  // Holding registers, pending-read tracking, round-robin pointer, counter
  logic [3:0]            vld_q,     vld_d;
  logic [DATA_WIDTH-1:0] addr_q[4];
  logic [DATA_WIDTH-1:0] addr_d[4];
  logic                  pend_q,    pend_d;
  logic [1:0]            pend_id_q, pend_id_d;
  logic [1:0]            ptr_q,     ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;

  logic [3:0]            rdy;
  logic [3:0]            req;
  logic [3:0]            hs;
  logic [2:0]            hs_cnt;
  logic                  gnt_any;
  logic [1:0]            gnt_id;
  logic [1:0]            scan_idx;
  logic                  fire;

  assign rdy = {bus.iEptyAddrRdy3, bus.iEptyAddrRdy2,
                bus.iEptyAddrRdy1, bus.iEptyAddrRdy0};

  // A port asks for an address only when its slot is empty and no read is
  // already on its way to it.
  always_comb begin
    req = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      req[n] = bus.iPortEn[n] & ~vld_q[n] & ~(pend_q & (pend_id_q == 2'(n)));
    end
  end

  // Round-robin search upward from the pointer; first requester wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = ptr_q;
    scan_idx = ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!gnt_any && req[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_idx;
      end
    end
  end

  // A grant only happens when there is something to read.
  assign fire = gnt_any & ~bus.iFifoEmpty;

  // Next-state: consume handshakes, land the pending read, track grants.
  always_comb begin
    hs     = vld_q & rdy;
    hs_cnt = 3'(hs[0]) + 3'(hs[1]) + 3'(hs[2]) + 3'(hs[3]);
    vld_d  = vld_q & ~hs;
    addr_d = addr_q;
    // The pending port had no valid entry when granted, so it cannot be
    // handshaking in the same cycle its address lands.
    if (pend_q) begin
      vld_d[pend_id_q]  = 1'b1;
      addr_d[pend_id_q] = bus.iFifoData;
    end
    pend_d    = fire;
    pend_id_d = fire ? gnt_id : pend_id_q;
    ptr_d     = fire ? (gnt_id + 2'd1) : ptr_q;
    cnt_d     = cnt_q + CNT_WIDTH'(hs_cnt);
  end

  // State registers; reset discards any read in flight.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      vld_q     <= 4'b0000;
      pend_q    <= 1'b0;
      pend_id_q <= 2'd0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      for (int n = 0; n < 4; n++) begin
        addr_q[n] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      for (int n = 0; n < 4; n++) begin
        addr_q[n] <= addr_d[n];
      end
    end
  end

  // The read strobe is combinational from state and inputs, so it is masked
  // by reset directly to stay low while reset is asserted.
  assign bus.oFifoRd       = fire & iRst_n;
  assign bus.oEptyAddr0    = addr_q[0];
  assign bus.oEptyAddr1    = addr_q[1];
  assign bus.oEptyAddr2    = addr_q[2];
  assign bus.oEptyAddr3    = addr_q[3];
  assign bus.oEptyAddrVld0 = vld_q[0];
  assign bus.oEptyAddrVld1 = vld_q[1];
  assign bus.oEptyAddrVld2 = vld_q[2];
  assign bus.oEptyAddrVld3 = vld_q[3];
  assign bus.oAllocCnt     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_free_addr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_free_addr_arb
// Description : Directed self-checking bench for free_addr_arb with a small
//               free-list FIFO model and a recycling random phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_free_addr_arb;
  localparam int DW = 12;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  free_addr_arb_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  free_addr_arb #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  // Input drivers
  logic [3:0] en_v  = 4'h0;
  logic [3:0] rdy_v = 4'h0;
  assign bus.iPortEn       = en_v;
  assign bus.iEptyAddrRdy0 = rdy_v[0];
  assign bus.iEptyAddrRdy1 = rdy_v[1];
  assign bus.iEptyAddrRdy2 = rdy_v[2];
  assign bus.iEptyAddrRdy3 = rdy_v[3];

  // Free-list FIFO model: data valid the cycle after a read strobe
  logic [DW-1:0] mem [256];
  logic [7:0]    wr_ptr = 8'd0;
  logic [7:0]    rd_ptr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= 8'd0;
      bus.iFifoData <= '0;
    end else if (bus.oFifoRd) begin
      bus.iFifoData <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end
  assign bus.iFifoEmpty = (rd_ptr == wr_ptr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [DW-1:0] a);
    mem[wr_ptr] = a;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    wr_ptr = 8'd0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] vld_vec();
    return {bus.oEptyAddrVld3, bus.oEptyAddrVld2, bus.oEptyAddrVld1, bus.oEptyAddrVld0};
  endfunction

  function automatic logic [DW-1:0] addr_of(input int n);
    case (n)
      0:       return bus.oEptyAddr0;
      1:       return bus.oEptyAddr1;
      2:       return bus.oEptyAddr2;
      default: return bus.oEptyAddr3;
    endcase
  endfunction

  logic [3:0]    v, hs, exp_v;
  logic [DW-1:0] recyc[$];
  int reads, hss, prev_rd, dup, p;

  initial begin
    // ---------------- Scenario 1: fill all four ports ----------------
    do_reset();
    for (int k = 1; k <= 4; k++) push(DW'(k));
    en_v  = 4'hF;
    rdy_v = 4'h0;
    cyc_start();
    check("rst_vld",   32'(vld_vec()), 32'h0);
    check("rst_rd",    32'(bus.oFifoRd), 32'h0);
    check("rst_cnt",   32'(bus.oAllocCnt), 32'h0);
    check("rst_addr0", 32'(bus.oEptyAddr0), 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      smp();
      exp_v = 4'h0;
      for (int n = 0; n < 4; n++) if (c >= n + 2) exp_v[n] = 1'b1;
      check("s1_rd",  32'(bus.oFifoRd), (c < 4) ? 32'h1 : 32'h0);
      check("s1_vld", 32'(vld_vec()), 32'(exp_v));
      cyc_start();
    end
    smp();
    for (int n = 0; n < 4; n++) check("s1_addr", 32'(addr_of(n)), 32'(n + 1));
    check("s1_cnt", 32'(bus.oAllocCnt), 32'h0);

    // ---------------- Scenario 2: port 2 alone, always ready ----------------
    do_reset();
    for (int k = 0; k < 100; k++) push(DW'(12'h200 + k));
    en_v  = 4'b0100;
    rdy_v = 4'b0100;
    rst_n = 1'b1;
    for (int c = 0; c < 302; c++) begin
      smp();
      check("s2_rd",  32'(bus.oFifoRd), (c % 3 == 0 && c < 300) ? 32'h1 : 32'h0);
      check("s2_vld", 32'(vld_vec()), (c % 3 == 2 && c < 300) ? 32'h4 : 32'h0);
      if (c % 3 == 2 && c < 300) check("s2_addr", 32'(bus.oEptyAddr2), 32'(12'h200 + c / 3));
      cyc_start();
    end
    smp();
    check("s2_cnt", 32'(bus.oAllocCnt), 32'd100);

    // ---------------- Scenario 3: all ports always ready ----------------
    do_reset();
    for (int k = 0; k < 8; k++) push(DW'(12'h300 + k));
    en_v  = 4'hF;
    rdy_v = 4'hF;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      smp();
      exp_v = (c >= 2 && c < 10) ? (4'b0001 << ((c - 2) % 4)) : 4'h0;
      check("s3_rd",  32'(bus.oFifoRd), (c < 8) ? 32'h1 : 32'h0);
      check("s3_vld", 32'(vld_vec()), 32'(exp_v));
      if (c >= 2 && c < 10) check("s3_addr", 32'(addr_of((c - 2) % 4)), 32'(12'h300 + c - 2));
      cyc_start();
    end
    smp();
    check("s3_cnt", 32'(bus.oAllocCnt), 32'd8);

    // ---------------- Scenario 4: hold while not ready, disable port 1 ----------------
    do_reset();
    push(12'h0AB); push(12'h0AC); push(12'h0AD);
    en_v  = 4'b0010;
    rdy_v = 4'h0;
    rst_n = 1'b1;
    smp();
    check("s4_grant", 32'(bus.oFifoRd), 32'h1);
    cyc_start();
    en_v = 4'h0;
    smp();
    check("s4_rd_off",  32'(bus.oFifoRd), 32'h0);
    check("s4_vld_pnd", 32'(vld_vec()), 32'h0);
    cyc_start();
    smp();
    check("s4_land_vld",  32'(vld_vec()), 32'h2);
    check("s4_land_addr", 32'(bus.oEptyAddr1), 32'h0AB);
    for (int c = 0; c < 20; c++) begin
      cyc_start();
      smp();
      check("s4_hold_vld",  32'(vld_vec()), 32'h2);
      check("s4_hold_addr", 32'(bus.oEptyAddr1), 32'h0AB);
      check("s4_hold_rd",   32'(bus.oFifoRd), 32'h0);
    end
    cyc_start();
    rdy_v = 4'b0010;
    smp();
    check("s4_hs_vld", 32'(vld_vec()), 32'h2);
    cyc_start();
    rdy_v = 4'h0;
    smp();
    check("s4_post_vld", 32'(vld_vec()), 32'h0);
    check("s4_cnt",      32'(bus.oAllocCnt), 32'd1);
    for (int c = 0; c < 5; c++) begin
      cyc_start();
      smp();
      check("s4_no_grant", 32'(bus.oFifoRd), 32'h0);
      check("s4_idle_vld", 32'(vld_vec()), 32'h0);
    end

    // ---------------- Scenario 5: async reset with a read in flight ----------------
    do_reset();
    push(12'h400); push(12'h401); push(12'h402);
    en_v  = 4'b0110;
    rdy_v = 4'h0;
    rst_n = 1'b1;
    smp();
    check("s5_g1", 32'(bus.oFifoRd), 32'h1);
    cyc_start();
    smp();
    check("s5_g2", 32'(bus.oFifoRd), 32'h1);
    cyc_start();
    smp();
    check("s5_pre_vld",  32'(vld_vec()), 32'h2);
    check("s5_pre_addr", 32'(bus.oEptyAddr1), 32'h400);
    rst_n = 1'b0;
    #1;
    check("s5_async_vld",  32'(vld_vec()), 32'h0);
    check("s5_async_rd",   32'(bus.oFifoRd), 32'h0);
    check("s5_async_addr", 32'(bus.oEptyAddr1), 32'h0);
    wr_ptr = 8'd0;
    push(12'h500); push(12'h501);
    en_v = 4'hF;
    cyc_start();
    rst_n = 1'b1;
    smp();
    check("s5_rel_rd", 32'(bus.oFifoRd), 32'h1);
    cyc_start();
    smp();
    cyc_start();
    smp();
    check("s5_first_vld",  32'(vld_vec()), 32'h1);
    check("s5_first_addr", 32'(bus.oEptyAddr0), 32'h500);

    // ---------------- Scenario 6: random enable/ready with recycling ----------------
    do_reset();
    for (int k = 0; k < 16; k++) push(DW'(12'h600 + k));
    rst_n   = 1'b1;
    reads   = 0;
    hss     = 0;
    prev_rd = 0;
    for (int c = 0; c < 2000; c++) begin
      en_v  = 4'($urandom_range(0, 15));
      rdy_v = 4'($urandom_range(0, 15));
      smp();
      v = vld_vec();
      hs = v & rdy_v;
      check("s6_inv", 32'(reads - hss), 32'($countones(v) + prev_rd));
      dup = 0;
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++)
          if (v[i] && v[j] && addr_of(i) == addr_of(j)) dup = 1;
      check("s6_dup", 32'(dup), 32'h0);
      if (bus.iFifoEmpty) check("s6_rd_empty", 32'(bus.oFifoRd), 32'h0);
      p = int'(bus.oFifoRd);
      reads   = reads + p;
      hss     = hss + $countones(hs);
      prev_rd = p;
      for (int n = 0; n < 4; n++) if (hs[n]) recyc.push_back(addr_of(n));
      cyc_start();
      while (recyc.size() > 0) push(recyc.pop_front());
    end
    smp();
    check("s6_cnt", 32'(bus.oAllocCnt), 32'(hss % 65536));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
